stopwatch_ctrl: RTL and testbench

Control and time-keeping core of the stopwatch. It consumes single-cycle enable ticks from the divider stage (count, adjust and display-scan rates) and the debounced button/switch inputs. It sequences the run/pause/adjust modes and keeps the MM:SS value in BCD. It also time-multiplexes the four digits onto the shared seven-segment anode/digit bus.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/bcd_mod60_counter.sv | 60 ++++++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control core.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package stopwatch_pkg;

    // Mode encoding is visible on state_o. Code 3 is never entered on purpose.
    // If it is ever reached, the FSM steers it back to RUN.
    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_PAUSED  = 2'd1,
        MODE_ADJUST  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    localparam int NUM_DIGITS_DEFAULT = 4;
    localparam int SEC_MAX_DEFAULT    = 59;
    localparam int MIN_MAX_DEFAULT    = 59;

    // Scan order: index 0 is the rightmost digit (seconds ones).
    localparam logic [1:0] SCAN_SEC_ONES = 2'd0;
    localparam logic [1:0] SCAN_SEC_TENS = 2'd1;
    localparam logic [1:0] SCAN_MIN_ONES = 2'd2;
    localparam logic [1:0] SCAN_MIN_TENS = 2'd3;

    // One-hot active-low anode enable for a scan index.
    function automatic logic [3:0] scan_anode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter that wraps from MAX to 00, with a carry pulse at the wrap.
// Latency: inc in cycle N shows on tens/ones in cycle N+1; carry is same-cycle with inc.
// Backpressure: none; every inc is accepted.
//
// Ports:
//   clk        clock; all state on posedge
//   clr        synchronous clear to 00 (wins over inc)
//   inc        one-cycle increment enable
//   tens/ones  registered BCD value
//   carry      high in the cycle an inc wraps MAX -> 00
module bcd_mod60_counter #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] TENS_MAX = 4'(MAX / 10);
    localparam logic [3:0] ONES_MAX = 4'(MAX % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_max;

    always_comb begin
        at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
        // Carry is combinational so the next counter in the chain increments in
        // the same cycle as this one wraps.
        carry  = inc && at_max && !clr;
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 4'd1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tens_q <= tens_d;
        ones_q <= ones_d;
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: run/pause/adjust FSM, MM:SS BCD time, blink and digit scan.
// Latency: ticks and mode inputs sampled in cycle N show on outputs in cycle N+1.
// Backpressure: none; every tick and pulse is consumed in its cycle.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   tick_1hz / tick_2hz / tick_scan   one-cycle rate enables (count, adjust+blink, scan)
//   pause_pulse, adj, sel             debounced controls (pulse, level, level)
//   min_tens..sec_ones                registered BCD time
//   an, digit, blank                  scanned display bus, decoded from registered state
//   state_o                           current mode
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
    parameter int SEC_MAX    = SEC_MAX_DEFAULT,
    parameter int MIN_MAX    = MIN_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_scan,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] an,
    output logic [3:0] digit,
    output logic       blank,
    output logic [1:0] state_o
);

    localparam logic [1:0] SCAN_LAST = 2'(NUM_DIGITS - 1);

    mode_e      state_q, state_d;
    logic [1:0] scan_idx_q, scan_idx_d;
    logic       blink_q, blink_d;
    // Registered copy of sel so blank depends on state only, never on a live input.
    logic       sel_q, sel_d;

    logic       sec_inc, min_inc, sec_carry, min_carry_unused;
    logic       in_run, in_adjust, sec_digit;

    assign in_run    = (state_q == MODE_RUN);
    assign in_adjust = (state_q == MODE_ADJUST);

    // Increments use the pre-transition mode, so a tick coinciding with a mode
    // change is handled as the old mode dictates.
    assign sec_inc = (in_run && tick_1hz) || (in_adjust && sel && tick_2hz);
    // Seconds carry only ripples into minutes while running; adjust has no carry.
    assign min_inc = (in_run && sec_carry) || (in_adjust && !sel && tick_2hz);

    bcd_mod60_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .clr   (rst),
        .inc   (sec_inc),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    // Minutes wrap 59:59 -> 00:00 silently; the carry has no consumer.
    bcd_mod60_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .clr   (rst),
        .inc   (min_inc),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry_unused)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_RUN: begin
                if (adj)              state_d = MODE_ADJUST;
                else if (pause_pulse) state_d = MODE_PAUSED;
            end
            MODE_PAUSED: begin
                if (adj)              state_d = MODE_ADJUST;
                else if (pause_pulse) state_d = MODE_RUN;
            end
            MODE_ADJUST: begin
                if (!adj)             state_d = MODE_PAUSED;
            end
            default:                  state_d = MODE_RUN;
        endcase

        blink_d    = tick_2hz ? !blink_q : blink_q;
        scan_idx_d = scan_idx_q;
        if (tick_scan) begin
            scan_idx_d = (scan_idx_q == SCAN_LAST) ? 2'd0 : scan_idx_q + 2'd1;
        end
        sel_d = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MODE_RUN;
            scan_idx_q <= 2'd0;
            blink_q    <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            blink_q    <= blink_d;
            sel_q      <= sel_d;
        end
    end

    assign state_o = state_q;
    assign an      = scan_anode(scan_idx_q);

    always_comb begin
        digit = sec_ones;
        case (scan_idx_q)
            SCAN_SEC_ONES: digit = sec_ones;
            SCAN_SEC_TENS: digit = sec_tens;
            SCAN_MIN_ONES: digit = min_ones;
            SCAN_MIN_TENS: digit = min_tens;
            default:       digit = sec_ones;
        endcase
    end

    // Only the field being adjusted flashes; the other field stays lit.
    assign sec_digit = (scan_idx_q == SCAN_SEC_ONES) || (scan_idx_q == SCAN_SEC_TENS);
    assign blank     = in_adjust && blink_q && (sel_q ? sec_digit : !sec_digit);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_scan = 1'b0;
    logic       pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, an, digit;
    logic       blank;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .tick_scan   (tick_scan),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .an          (an),
        .digit       (digit),
        .blank       (blank),
        .state_o     (state_o)
    );

    typedef struct {
        logic [15:0] t;
        logic [1:0]  st;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic        bl;
        int          ht, hst, han, hdig, hbl;   // hand-computed values, -1 = not given
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: total seconds, mode, scan index, blink phase, registered sel.
    int   m_t = 0, m_st = 0, m_idx = 0;
    bit   m_blink = 0, m_sel = 0;
    int   h_t = -1, h_st = -1, h_an = -1, h_dig = -1, h_bl = -1;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; pop one expectation per cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("time",  {min_tens, min_ones, sec_tens, sec_ones}, e.t);
            check("state", 16'(state_o), 16'(e.st));
            check("an",    16'(an), 16'(e.an));
            check("digit", 16'(digit), 16'(e.dig));
            check("blank", 16'(blank), 16'(e.bl));
            if (e.ht   >= 0) check("hand_time",  {min_tens, min_ones, sec_tens, sec_ones}, 16'(e.ht));
            if (e.hst  >= 0) check("hand_state", 16'(state_o), 16'(e.hst));
            if (e.han  >= 0) check("hand_an",    16'(an), 16'(e.han));
            if (e.hdig >= 0) check("hand_digit", 16'(digit), 16'(e.hdig));
            if (e.hbl  >= 0) check("hand_blank", 16'(blank), 16'(e.hbl));
        end
    end

    // One clock of stimulus; the expected response is queued for the monitor.
    task automatic cyc(input bit r, input bit t1, input bit t2, input bit ts,
                       input bit pp, input bit a, input bit s);
        exp_t e;
        int   mm, ss, nst;
        rst = r; tick_1hz = t1; tick_2hz = t2; tick_scan = ts;
        pause_pulse = pp; adj = a; sel = s;
        @(posedge clk);
        if (r) begin
            m_t = 0; m_st = 0; m_idx = 0; m_blink = 0; m_sel = 0;
        end else begin
            mm = m_t / 60;
            ss = m_t % 60;
            if (m_st == 0 && t1) begin
                m_t = (m_t + 1) % 3600;
            end else if (m_st == 2 && t2) begin
                if (s) ss = (ss + 1) % 60;
                else   mm = (mm + 1) % 60;
                m_t = mm * 60 + ss;
            end
            nst = m_st;
            case (m_st)
                0:       begin if (a) nst = 2; else if (pp) nst = 1; end
                1:       begin if (a) nst = 2; else if (pp) nst = 0; end
                default: begin if (!a) nst = 1; end
            endcase
            m_st = nst;
            if (t2) m_blink = !m_blink;
            if (ts) m_idx = (m_idx + 1) % 4;
            m_sel = s;
        end
        e.t   = to_bcd(m_t);
        e.st  = 2'(m_st);
        e.an  = 4'b1111;
        e.an[m_idx] = 1'b0;
        e.dig = e.t[4*m_idx +: 4];
        e.bl  = (m_st == 2) && m_blink && (m_sel ? (m_idx < 2) : (m_idx >= 2));
        e.ht = h_t; e.hst = h_st; e.han = h_an; e.hdig = h_dig; e.hbl = h_bl;
        sb_q.push_back(e);
        h_t = -1; h_st = -1; h_an = -1; h_dig = -1; h_bl = -1;
        #1;
        rst = 0; tick_1hz = 0; tick_2hz = 0; tick_scan = 0; pause_pulse = 0;
    endtask

    task automatic run1(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, adj, sel);
    endtask

    task automatic run2(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, adj, sel);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset values.
        h_t = 0; h_st = 0; h_an = 'he; h_dig = 0; h_bl = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // 61 seconds -> 01:01.
        run1(60);
        h_t = 'h0101; run1(1);

        // Adjust up to 59:59, then one run tick wraps to 00:00.
        h_st = 2; cyc(0, 0, 0, 0, 0, 1, 0);
        run2(57);
        h_t = 'h5901; run2(1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        run2(57);
        h_t = 'h5959; run2(1);
        h_st = 1; cyc(0, 0, 0, 0, 0, 0, 1);
        h_st = 0; cyc(0, 0, 0, 0, 1, 0, 1);
        h_t = 'h0000; run1(1);

        // Pause / resume.
        run1(4);
        h_t = 'h0005; run1(1);
        h_st = 1; cyc(0, 0, 0, 0, 1, 0, 0);
        run1(2);
        h_t = 'h0005; h_st = 1; run1(1);
        h_st = 0; cyc(0, 0, 0, 0, 1, 0, 0);
        h_t = 'h0006; run1(1);

        // pause_pulse with tick_1hz at 00:09: increment then pause.
        run1(3);
        h_t = 'h0010; h_st = 1; cyc(0, 1, 0, 0, 1, 0, 0);
        // adj wins over pause_pulse.
        h_st = 2; cyc(0, 0, 0, 0, 1, 1, 0);
        h_st = 1; cyc(0, 0, 0, 0, 0, 0, 0);
        h_st = 0; cyc(0, 0, 0, 0, 1, 0, 0);
        run1(19);
        h_t = 'h0030; run1(1);

        // Minutes adjust, tick_1hz ignored, seconds adjust without carry.
        h_st = 2; cyc(0, 0, 0, 0, 0, 1, 0);
        run2(2);
        h_t = 'h0330; run2(1);
        h_t = 'h0330; cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        run2(27);
        h_t = 'h0358; run2(1);
        run2(1);
        h_t = 'h0300; run2(1);
        h_st = 1; cyc(0, 0, 0, 0, 0, 0, 1);

        // Blink over all scan positions, seconds selected then minutes selected.
        cyc(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, (i % 3 == 0), 1, 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, (i % 3 == 1), 1, 0, 1, 0);
        h_st = 1; h_bl = 0; cyc(0, 0, 0, 0, 0, 0, 0);

        // adj rising together with tick_1hz in RUN: increment still happens.
        h_st = 0; cyc(0, 0, 0, 0, 1, 0, 0);
        h_st = 2; cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Reset with adj held: RUN first, ADJUST one cycle later.
        h_t = 0; h_st = 0; h_an = 'he; h_dig = 0; cyc(1, 0, 0, 0, 0, 1, 0);
        h_st = 2; cyc(0, 0, 0, 0, 0, 1, 0);
        run2(11);
        h_t = 'h1200; run2(1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        run2(33);
        h_t = 'h1234; run2(1);
        h_st = 1; h_an = 'he; h_dig = 4; cyc(0, 0, 0, 0, 0, 0, 1);

        // Scan sequence at 12:34.
        h_an = 'hd; h_dig = 3; cyc(0, 0, 0, 1, 0, 0, 0);
        h_an = 'hb; h_dig = 2; cyc(0, 0, 0, 1, 0, 0, 0);
        h_an = 'h7; h_dig = 1; cyc(0, 0, 0, 1, 0, 0, 0);
        h_an = 'he; h_dig = 4; cyc(0, 0, 0, 1, 0, 0, 0);
        h_an = 'hd; h_dig = 3; cyc(0, 0, 0, 1, 0, 0, 0);
        h_an = 'hb; h_dig = 2; cyc(0, 0, 0, 1, 0, 0, 0);
        // Reset mid-scan.
        h_an = 'he; h_dig = 0; h_t = 0; h_st = 0; h_bl = 0; cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
